result_packer: RTL and testbench



---
 rtl/result_packer_pkg.sv | 28 ++
 rtl/result_packer_if.sv | 11 +
 rtl/packer_out_slot.sv | 41 ++++
 rtl/result_packer.sv | 124 ++++++++++++
 tb/tb_result_packer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_packer_pkg.sv
// Shared types and constants for the result packer (fp16 pairs into 32-bit FIFO words).
package result_packer_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned OUT_W      = 32;
  localparam int unsigned COUNT_W    = 10;
  localparam int unsigned WCNT_W     = 16;
  localparam int unsigned FIFO_DEPTH = 1023;
  localparam int unsigned HEADROOM   = 4;

  localparam logic [DATA_W-1:0] PAD_HALF = 16'h0000;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } word_t;

  // Count is reported with latency, so treat the last HEADROOM words as unavailable.
  function automatic logic almost_full(input logic [COUNT_W-1:0] cnt);
    return 32'(cnt) >= (FIFO_DEPTH - HEADROOM);
  endfunction

endpackage

// File: rtl/result_packer_if.sv
// Engine result stream (valid/ready) between the compute engine and the result packer.
interface result_packer_if;
  import result_packer_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/packer_out_slot.sv
// Single-entry output register feeding the result FIFO; drains when not stalled and
// may be reloaded in the same cycle it drains.
module packer_out_slot
  import result_packer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  word_t              load_data,
  input  logic               fifo_full,
  input  logic [COUNT_W-1:0] fifo_wr_count,
  output logic               out_vld,
  output logic               fifo_wr_en,
  output logic [OUT_W-1:0]   fifo_din
);

  logic  out_vld_q, out_vld_d;
  word_t data_q, data_d;
  logic  stall_c;

  always_comb begin
    stall_c    = fifo_full | almost_full(fifo_wr_count);
    fifo_wr_en = ~rst & out_vld_q & ~stall_c;
    out_vld_d  = load | (out_vld_q & ~fifo_wr_en);
    data_d     = load ? load_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      data_q    <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      data_q    <= data_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign fifo_din = data_q;

endmodule

// File: rtl/result_packer.sv
// Packs pairs of fp16 results into 32-bit FIFO words with end-of-layer flush.
// PACKER_HI_FIRST_EN: first sample of a pair goes to [31:16] instead of [15:0].
module result_packer
  import result_packer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  result_packer_if.slave     in_if,
  input  logic               flush,
  input  logic               fifo_full,
  input  logic [COUNT_W-1:0] fifo_wr_count,
  output logic               fifo_wr_en,
  output logic [OUT_W-1:0]   fifo_din,
  output logic [WCNT_W-1:0]  word_count,
  output logic               flush_done,
  output logic               busy
);

  function automatic word_t pack_word(input logic [DATA_W-1:0] first,
                                      input logic [DATA_W-1:0] second);
    word_t w;
`ifdef PACKER_HI_FIRST_EN
    w.hi = first;
    w.lo = second;
`else
    w.hi = second;
    w.lo = first;
`endif
    return w;
  endfunction

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   low_q, low_d;
  logic                flush_pend_q, flush_pend_d;
  logic                pad_pend_q, pad_pend_d;
  logic [WCNT_W-1:0]   word_count_q, word_count_d;
  logic                flush_done_q, flush_done_d;
  logic                busy_q, busy_d;

  logic                out_vld;
  logic                load_c;
  word_t               load_data_c;
  logic                slot_free_c, in_ready_c, accept_c;
  logic                pend_now_c, slot_vld_next_c;

  packer_out_slot u_slot (
    .clk           (clk),
    .rst           (rst),
    .load          (load_c),
    .load_data     (load_data_c),
    .fifo_full     (fifo_full),
    .fifo_wr_count (fifo_wr_count),
    .out_vld       (out_vld),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din)
  );

  // Pairing and pad selection; a pad only ever covers the half held when flush arrived.
  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    pad_pend_d  = pad_pend_q;
    load_c      = 1'b0;
    load_data_c = '0;

    slot_free_c = ~out_vld | fifo_wr_en;
    in_ready_c  = ~rst & ((state_q == S_EMPTY) | slot_free_c);
    accept_c    = in_if.in_valid & in_ready_c;

    if (accept_c) begin
      if (state_q == S_EMPTY) begin
        low_d   = in_if.in_data;
        state_d = S_HALF;
      end else begin
        load_c      = 1'b1;
        load_data_c = pack_word(low_q, in_if.in_data);
        state_d     = S_EMPTY;
      end
    end else if (pad_pend_q && (state_q == S_HALF) && slot_free_c) begin
      load_c      = 1'b1;
      load_data_c = pack_word(low_q, PAD_HALF);
      state_d     = S_EMPTY;
    end

    if (flush && !flush_pend_q && (state_q == S_HALF) && !accept_c) pad_pend_d = 1'b1;
    if (state_d == S_EMPTY) pad_pend_d = 1'b0;
  end

  // Flush retires once nothing from before the flush remains outside the FIFO.
  always_comb begin
    pend_now_c      = flush_pend_q | flush;
    slot_vld_next_c = load_c | (out_vld & ~fifo_wr_en);
    flush_done_d    = pend_now_c & ~pad_pend_d & ~slot_vld_next_c;
    flush_pend_d    = pend_now_c & ~flush_done_d;
    busy_d          = (state_d == S_HALF) | slot_vld_next_c | flush_pend_d;
    word_count_d    = word_count_q + WCNT_W'(fifo_wr_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      low_q        <= '0;
      flush_pend_q <= 1'b0;
      pad_pend_q   <= 1'b0;
      word_count_q <= '0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      low_q        <= low_d;
      flush_pend_q <= flush_pend_d;
      pad_pend_q   <= pad_pend_d;
      word_count_q <= word_count_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
    end
  end

  assign in_if.in_ready = in_ready_c;
  assign word_count     = word_count_q;
  assign flush_done     = flush_done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed scenarios plus randomized traffic
// against a queue-based model of the expected FIFO word stream.
module tb_result_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fifo_full;
  logic [9:0]  fifo_wr_count;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic [15:0] word_count;
  logic        flush_done;
  logic        busy;

  result_packer_if pin ();

  result_packer dut (
    .clk           (clk),
    .rst           (rst),
    .in_if         (pin),
    .flush         (flush),
    .fifo_full     (fifo_full),
    .fifo_wr_count (fifo_wr_count),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .word_count    (word_count),
    .flush_done    (flush_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          m_held_v;
  logic [15:0] m_held;
  int          writes_seen;
  int          cyc = 0;
  int          last_wr_cyc = -1;
  bit          last_acc, last_wr, last_done;
  int          last_cyc;
  logic [15:0] last_wc;

  function automatic logic [31:0] pack(input logic [15:0] first, input logic [15:0] second);
`ifdef PACKER_HI_FIRST_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  function automatic bit stall_now();
    return fifo_full || (fifo_wr_count >= 10'd1019);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Every FIFO write must match the next expected word and never happen under stall.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (word_count !== 16'(writes_seen)) begin
        errors++;
        $display("FAIL word_count cyc=%0d got %0d want %0d", cyc, word_count, writes_seen);
      end
      if (fifo_wr_en) begin
        checks++;
        if (stall_now()) begin
          errors++;
          $display("FAIL write_under_stall cyc=%0d full=%0b count=%0d", cyc, fifo_full, fifo_wr_count);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_write cyc=%0d got %h want none", cyc, fifo_din);
        end else begin
          logic [31:0] w;
          w = exp_q.pop_front();
          if (fifo_din !== w) begin
            errors++;
            $display("FAIL fifo_din cyc=%0d got %h want %h", cyc, fifo_din, w);
          end
        end
        writes_seen++;
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic tick(input bit v, input logic [15:0] d, input bit fl);
    bit hb;
    pin.in_valid = v;
    pin.in_data  = d;
    flush        = fl;
    @(negedge clk);
    last_acc  = v && pin.in_ready;
    last_wr   = fifo_wr_en;
    last_done = flush_done;
    last_cyc  = cyc;
    last_wc   = word_count;
    if (!rst) begin
      checks++;
      if (!stall_now() && pin.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_unstalled cyc=%0d got %b want 1", cyc, pin.in_ready);
      end
      hb = m_held_v;
      if (last_acc) begin
        if (m_held_v) begin
          exp_q.push_back(pack(m_held, d));
          m_held_v = 1'b0;
        end else begin
          m_held   = d;
          m_held_v = 1'b1;
        end
      end
      if (fl && hb && !last_acc) begin
        exp_q.push_back(pack(m_held, 16'h0000));
        m_held_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    pin.in_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pin.in_valid = 1'b0;
    flush = 1'b0;
    fifo_full = 1'b0;
    fifo_wr_count = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    m_held_v    = 1'b0;
    writes_seen = 0;
    last_wr_cyc = -1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < max_cyc && done_cyc < 0; i++) begin
      tick(1'b0, 16'h0, 1'b0);
      if (last_done) done_cyc = last_cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pin.in_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got rdy=%b wr=%b want 0 0", pin.in_ready, fifo_wr_en);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (fifo_din !== 32'h0 || word_count !== 16'h0 || flush_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got din=%h wc=%0d done=%b busy=%b want 0 0 0 0",
               fifo_din, word_count, flush_done, busy);
    end
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    checks++;
    if (pin.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", pin.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    do_reset();
    tick(1'b1, 16'h3C00, 1'b0);
    tick(1'b1, 16'h4000, 1'b0);
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_din !== pack(16'h3C00, 16'h4000)) begin
      errors++;
      $display("FAIL basic_write got wr=%b din=%h want 1 %h", fifo_wr_en, fifo_din, pack(16'h3C00, 16'h4000));
    end
    @(posedge clk);
    #1;
    tick(1'b0, 16'h0, 1'b0);
    checks++;
    if (last_wc !== 16'd1 || last_wr !== 1'b0) begin
      errors++;
      $display("FAIL basic_count got wc=%0d wr=%b want 1 0", last_wc, last_wr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    fifo_wr_count = 10'd1019;
    tick(1'b1, 16'h0A0A, 1'b0);
    tick(1'b1, 16'h0B0B, 1'b0);
    tick(1'b1, 16'h0C0C, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        fifo_wr_count = 10'd0;
        fifo_full     = 1'b1;
      end
      tick(1'b1, 16'h0D0D, 1'b0);
      checks++;
      if (last_acc || last_wr || fifo_din !== pack(16'h0A0A, 16'h0B0B) || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold i=%0d got acc=%b wr=%b din=%h busy=%b want 0 0 %h 1",
                 i, last_acc, last_wr, fifo_din, busy, pack(16'h0A0A, 16'h0B0B));
      end
    end
    fifo_full     = 1'b0;
    fifo_wr_count = 10'd1018;
    tick(1'b1, 16'h0D0D, 1'b0);
    checks++;
    if (!last_acc || !last_wr) begin
      errors++;
      $display("FAIL stall_release got acc=%b wr=%b want 1 1", last_acc, last_wr);
    end
    fifo_wr_count = 10'd500;
    tick(1'b0, 16'h0, 1'b0);
    checks++;
    if (!last_wr || fifo_din !== pack(16'h0C0C, 16'h0D0D)) begin
      errors++;
      $display("FAIL stall_second got wr=%b din=%h want 1 %h", last_wr, fifo_din, pack(16'h0C0C, 16'h0D0D));
    end
    tick(1'b0, 16'h0, 1'b0);
    checks++;
    if (last_wc !== 16'd2) begin
      errors++;
      $display("FAIL stall_count got %0d want 2", last_wc);
    end
  endtask

  task automatic test_flush_odd();
    int dc;
    do_reset();
    tick(1'b1, 16'h0001, 1'b0);
    tick(1'b1, 16'h0002, 1'b0);
    tick(1'b1, 16'h0003, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    wait_done(20, dc);
    checks++;
    if (dc < 0 || dc != last_wr_cyc + 1 || exp_q.size() != 0 || writes_seen != 2 || last_wc !== 16'd2) begin
      errors++;
      $display("FAIL flush_odd got done_cyc=%0d last_wr=%0d left=%0d wc=%0d want done=last_wr+1 left=0 wc=2",
               dc, last_wr_cyc, exp_q.size(), last_wc);
    end
    tick(1'b0, 16'h0, 1'b0);
    checks++;
    if (last_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_odd_pulse got done=%b busy=%b want 0 0", last_done, busy);
    end
  endtask

  task automatic test_flush_same();
    int dc, acc_cyc;
    do_reset();
    tick(1'b1, 16'h1234, 1'b0);
    tick(1'b1, 16'hABCD, 1'b1);
    acc_cyc = last_cyc;
    wait_done(20, dc);
    checks++;
    if (dc < 0 || writes_seen != 1 || last_wr_cyc != acc_cyc + 1 || dc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL flush_same got done=%0d writes=%0d wr_cyc=%0d acc=%0d want writes=1 wr=acc+1 done=wr+1",
               dc, writes_seen, last_wr_cyc, acc_cyc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fifo_full = 1'b1;
    tick(1'b1, 16'h0011, 1'b0);
    tick(1'b1, 16'h0022, 1'b0);
    tick(1'b1, 16'h0033, 1'b0);
    rst = 1'b1;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_held_v    = 1'b0;
    writes_seen = 0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got wr=%b busy=%b want 0 0", fifo_wr_en, busy);
    end
    @(posedge clk);
    #1;
    tick(1'b1, 16'h0005, 1'b0);
    tick(1'b1, 16'h0006, 1'b0);
    tick(1'b0, 16'h0, 1'b0);
    checks++;
    if (!last_wr || fifo_din !== pack(16'h0005, 16'h0006)) begin
      errors++;
      $display("FAIL reset_mid_resume got wr=%b din=%h want 1 %h", last_wr, fifo_din, pack(16'h0005, 16'h0006));
    end
  endtask

  task automatic test_flush_empty();
    repeat (2) tick(1'b0, 16'h0, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b0, 16'h0, 1'b0);
    checks++;
    if (last_done !== 1'b1 || last_wr !== 1'b0 || last_wc !== 16'(writes_seen)) begin
      errors++;
      $display("FAIL flush_empty got done=%b wr=%b wc=%0d want 1 0 %0d", last_done, last_wr, last_wc, writes_seen);
    end
    tick(1'b0, 16'h0, 1'b0);
    checks++;
    if (last_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty_pulse got %b want 0", last_done);
    end
  endtask

  task automatic test_double_flush();
    int pulses;
    do_reset();
    fifo_full = 1'b1;
    tick(1'b1, 16'h00A1, 1'b0);
    tick(1'b1, 16'h00A2, 1'b0);
    tick(1'b1, 16'h00A3, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b0, 16'h0, 1'b1);
    fifo_full = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 16'h0, 1'b0);
      if (last_done) pulses++;
    end
    checks++;
    if (pulses != 1 || exp_q.size() != 0 || writes_seen != 2) begin
      errors++;
      $display("FAIL double_flush got pulses=%0d left=%0d writes=%0d want 1 0 2", pulses, exp_q.size(), writes_seen);
    end
  endtask

  task automatic test_random();
    int dc;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 150; i++) begin
        fifo_full = ($urandom % 8) == 0;
        case ($urandom % 4)
          0:       fifo_wr_count = 10'($urandom_range(0, 1017));
          1:       fifo_wr_count = 10'd1018;
          2:       fifo_wr_count = 10'd1019;
          default: fifo_wr_count = 10'($urandom_range(1019, 1023));
        endcase
        tick(($urandom % 4) != 0, 16'($urandom), 1'b0);
      end
      fifo_full     = 1'b0;
      fifo_wr_count = 10'($urandom_range(0, 1018));
      tick(1'b0, 16'h0, 1'b1);
      wait_done(20, dc);
      checks++;
      if (dc < 0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_flush round=%0d got done=%0d left=%0d want done>=0 left=0", r, dc, exp_q.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pin.in_valid = 1'b0;
    pin.in_data = '0;
    flush = 1'b0;
    fifo_full = 1'b0;
    fifo_wr_count = '0;
    m_held_v = 1'b0;
    m_held = '0;
    writes_seen = 0;
    test_reset();
    test_basic();
    test_stall();
    test_flush_odd();
    test_flush_same();
    test_reset_mid();
    test_flush_empty();
    test_double_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
